// File: rtl/cg_pkg.sv
// ============================================================================
// Module   : cg_pkg
// Brief    : Shared widths, sample types and FSM encodings for the collector.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cg_pkg;
    localparam int FRAME_LEN = 16;
    localparam int DW        = 7;
    localparam int SUM_W     = 11;
    localparam int IDX_W     = 4;

    typedef logic signed [DW-1:0]    sample_t;
    typedef logic signed [SUM_W-1:0] sum_t;

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_FILL  = 2'd1,
        C_DRAIN = 2'd2
    } cap_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_SEND = 1'b1
    } rd_state_t;
endpackage

`default_nettype wire

// File: rtl/cg_frame_bank.sv
// ============================================================================
// Module   : cg_frame_bank
// Brief    : One 16-sample frame store plus its latched sum/max/min.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cg_frame_bank
    import cg_pkg::*;
(
    input  logic             clk,
    input  logic             cg_en,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  sample_t          wr_data,
    input  logic             stat_en,
    input  sum_t             sum_in,
    input  sample_t          max_in,
    input  sample_t          min_in,
    input  logic [IDX_W-1:0] rd_addr,
    output sample_t          rd_data,
    output sum_t             sum_q,
    output sample_t          max_q,
    output sample_t          min_q
);
    sample_t mem [FRAME_LEN];

    // With cg_en low every register reloads each cycle; contents are unchanged.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (wr_en && (wr_addr == IDX_W'(i))) begin
                mem[i] <= wr_data;
            end else if (!cg_en) begin
                mem[i] <= mem[i];
            end
        end
        if (stat_en) begin
            sum_q <= sum_in;
            max_q <= max_in;
            min_q <= min_in;
        end else if (!cg_en) begin
            sum_q <= sum_q;
            max_q <= max_q;
            min_q <= min_q;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

`default_nettype wire

// File: rtl/cg_result_collector.sv
// ============================================================================
// Module   : cg_result_collector
// Brief    : Captures 16-sample result bursts into a ping-pong store and
//            replays each frame over valid/ready with sum/max/min on beat 15.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cg_result_collector
    import cg_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             cg_en,
    input  logic             in_valid,
    input  sample_t          in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output sample_t          out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output sum_t             out_sum,
    output sample_t          out_max,
    output sample_t          out_min,
    output logic             err_short,
    output logic             err_long,
    output logic             err_ovf
);
    cap_state_t       cstate;
    rd_state_t        rstate;
    logic [IDX_W-1:0] cnt;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       full;
    logic             long_armed;
    sum_t             acc_sum;
    sample_t          acc_max;
    sample_t          acc_min;

    logic             first;
    logic             wr_fire;
    logic             frame_done;
    logic [IDX_W-1:0] wr_addr;
    sum_t             sum_next;
    sample_t          max_next;
    sample_t          min_next;
    logic             handshake;
    logic             beat_end;
    logic             advance;
    logic             rd_bank;
    logic [IDX_W-1:0] rd_addr;
    logic             load_last;
    sample_t          bank_data [2];
    sum_t             bank_sum  [2];
    sample_t          bank_max  [2];
    sample_t          bank_min  [2];

    assign first      = (cstate == C_IDLE);
    assign wr_fire    = in_valid && ((first && !full[wr_ptr]) || (cstate == C_FILL));
    assign frame_done = in_valid && (cstate == C_FILL) && (cnt == IDX_W'(FRAME_LEN - 1));
    assign wr_addr    = first ? '0 : cnt;
    assign sum_next   = first ? sum_t'(in_data) : acc_sum + sum_t'(in_data);
    assign max_next   = (first || (in_data > acc_max)) ? in_data : acc_max;
    assign min_next   = (first || (in_data < acc_min)) ? in_data : acc_min;

    assign handshake  = out_valid && out_ready;
    assign beat_end   = (rstate == R_SEND) && handshake && out_last;
    assign advance    = (rstate == R_SEND) && handshake && !out_last;
    // Beat 15 accepted: look straight at the other bank so frames run seamlessly.
    assign rd_bank    = beat_end ? ~rd_ptr : rd_ptr;
    assign rd_addr    = advance ? out_idx + 1'b1 : '0;
    assign load_last  = (rd_addr == IDX_W'(FRAME_LEN - 1));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        cg_frame_bank u_bank (
            .clk     (clk),
            .cg_en   (cg_en),
            .wr_en   (wr_fire && (wr_ptr == 1'(b))),
            .wr_addr (wr_addr),
            .wr_data (in_data),
            .stat_en (frame_done && (wr_ptr == 1'(b))),
            .sum_in  (sum_next),
            .max_in  (max_next),
            .min_in  (min_next),
            .rd_addr (rd_addr),
            .rd_data (bank_data[b]),
            .sum_q   (bank_sum[b]),
            .max_q   (bank_max[b]),
            .min_q   (bank_min[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cstate     <= C_IDLE;
            cnt        <= '0;
            wr_ptr     <= 1'b0;
            long_armed <= 1'b0;
            acc_sum    <= '0;
            acc_max    <= '0;
            acc_min    <= '0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
            err_ovf    <= 1'b0;
        end else begin
            err_short <= 1'b0;
            err_long  <= 1'b0;
            err_ovf   <= 1'b0;
            case (cstate)
                C_IDLE: begin
                    if (in_valid) begin
                        if (!full[wr_ptr]) begin
                            acc_sum <= sum_next;
                            acc_max <= max_next;
                            acc_min <= min_next;
                            cnt     <= IDX_W'(1);
                            cstate  <= C_FILL;
                        end else begin
                            err_ovf    <= 1'b1;
                            long_armed <= 1'b0;
                            cstate     <= C_DRAIN;
                        end
                    end
                end
                C_FILL: begin
                    if (in_valid) begin
                        acc_sum <= sum_next;
                        acc_max <= max_next;
                        acc_min <= min_next;
                        if (frame_done) begin
                            cnt        <= '0;
                            wr_ptr     <= ~wr_ptr;
                            long_armed <= 1'b1;
                            cstate     <= C_DRAIN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        err_short <= 1'b1;
                        cnt       <= '0;
                        cstate    <= C_IDLE;
                    end
                end
                C_DRAIN: begin
                    if (in_valid) begin
                        if (long_armed) begin
                            err_long <= 1'b1;
                        end
                        long_armed <= 1'b0;
                    end else begin
                        cstate <= C_IDLE;
                    end
                end
                default: cstate <= C_IDLE;
            endcase
        end
    end

    // Set and clear never target the same bank: a filling bank is never full.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= '0;
        end else begin
            if (frame_done) full[wr_ptr] <= 1'b1;
            if (beat_end)   full[rd_ptr] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate    <= R_IDLE;
            rd_ptr    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_sum   <= '0;
            out_max   <= '0;
            out_min   <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (full[rd_ptr]) begin
                        out_valid <= 1'b1;
                        out_data  <= bank_data[rd_bank];
                        out_idx   <= rd_addr;
                        out_last  <= 1'b0;
                        rstate    <= R_SEND;
                    end
                end
                R_SEND: begin
                    if (beat_end) begin
                        rd_ptr   <= ~rd_ptr;
                        out_sum  <= '0;
                        out_max  <= '0;
                        out_min  <= '0;
                        out_last <= 1'b0;
                        out_idx  <= '0;
                        if (full[rd_bank]) begin
                            out_data <= bank_data[rd_bank];
                        end else begin
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            rstate    <= R_IDLE;
                        end
                    end else if (advance) begin
                        out_data <= bank_data[rd_bank];
                        out_idx  <= rd_addr;
                        out_last <= load_last;
                        out_sum  <= load_last ? bank_sum[rd_bank] : '0;
                        out_max  <= load_last ? bank_max[rd_bank] : '0;
                        out_min  <= load_last ? bank_min[rd_bank] : '0;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_cg_result_collector.sv
// ============================================================================
// Module   : tb_cg_result_collector
// Brief    : Scoreboard bench for cg_result_collector with directed frames.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cg_result_collector;
    import cg_pkg::*;

    logic       clk = 1'b0;
    logic       rst, cg_en, in_valid, out_ready;
    sample_t    in_data;
    logic       out_valid, out_last, err_short, err_long, err_ovf;
    sample_t    out_data, out_max, out_min;
    logic [3:0] out_idx;
    sum_t       out_sum;

    typedef struct packed {
        sample_t    d;
        logic [3:0] idx;
        logic       last;
        sum_t       sum;
        sample_t    mx;
        sample_t    mn;
    } beat_t;

    beat_t      q[$];
    sample_t    smp [18];
    int         total = 0, bad = 0;
    int         n_short = 0, n_long = 0, n_ovf = 0, beats = 0;
    logic       hold_pend = 1'b0;
    sample_t    held_d;
    logic [3:0] held_i;

    cg_result_collector dut (
        .clk       (clk),
        .rst       (rst),
        .cg_en     (cg_en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_sum   (out_sum),
        .out_max   (out_max),
        .out_min   (out_min),
        .err_short (err_short),
        .err_long  (err_long),
        .err_ovf   (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: handshakes pop the scoreboard; stalled beats must hold.
    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                total++;
                if (!(out_valid && out_data == held_d && out_idx == held_i)) begin
                    bad++;
                    $display("FAIL hold: got v=%0b d=%0d idx=%0d expected v=1 d=%0d idx=%0d",
                             out_valid, out_data, out_idx, held_d, held_i);
                end
            end
            hold_pend = out_valid && !out_ready;
            held_d    = out_data;
            held_i    = out_idx;
            if (out_valid && out_ready) begin
                beat_t act, e;
                beats++;
                total++;
                act = '{d: out_data, idx: out_idx, last: out_last,
                        sum: out_sum, mx: out_max, mn: out_min};
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL beat: unexpected beat d=%0d idx=%0d", out_data, out_idx);
                end else begin
                    e = q.pop_front();
                    if (act != e) begin
                        bad++;
                        $display("FAIL beat: got d=%0d idx=%0d last=%0b sum=%0d max=%0d min=%0d expected d=%0d idx=%0d last=%0b sum=%0d max=%0d min=%0d",
                                 act.d, act.idx, act.last, act.sum, act.mx, act.mn,
                                 e.d, e.idx, e.last, e.sum, e.mx, e.mn);
                    end
                end
            end
            if (err_short) n_short++;
            if (err_long)  n_long++;
            if (err_ovf)   n_ovf++;
        end
    end

    task automatic burst(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = smp[i];
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic push_frame(input int s, input int mx, input int mn);
        beat_t e;
        for (int i = 0; i < 16; i++) begin
            e.d    = smp[i];
            e.idx  = 4'(i);
            e.last = (i == 15);
            e.sum  = (i == 15) ? sum_t'(s) : '0;
            e.mx   = (i == 15) ? sample_t'(mx) : '0;
            e.mn   = (i == 15) ? sample_t'(mn) : '0;
            q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while (q.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        @(posedge clk); #1;
        chk(name, q.size(), 0);
    endtask

    initial begin
        int b0;
        rst = 1'b1; cg_en = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {out_valid, out_data, out_idx, out_last, out_sum,
                              out_max, out_min, err_short, err_long, err_ovf}, 0);
        rst = 1'b0;

        // Ramp frame with latency check
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) smp[i] = sample_t'(i);
        push_frame(120, 15, 0);
        burst(16);
        chk("latency_before", out_valid, 0);
        @(posedge clk); #1;
        chk("latency_first", {out_valid, out_idx}, {1'b1, 4'd0});
        wait_drain("drain_ramp", 60);

        // Signed extremes, free-running bank clocks
        cg_en = 1'b0;
        for (int i = 0; i < 16; i++) smp[i] = -7'sd1;
        smp[3] = -7'sd64;
        smp[9] = 7'sd63;
        push_frame(-15, 63, -64);
        burst(16);
        wait_drain("drain_signed", 60);

        for (int i = 0; i < 16; i++) smp[i] = -7'sd64;
        push_frame(-1024, -64, -64);
        burst(16);
        for (int i = 0; i < 16; i++) smp[i] = 7'sd63;
        push_frame(1008, 63, 63);
        burst(16);
        wait_drain("drain_bounds", 80);
        cg_en = 1'b1;

        // Backpressure
        for (int i = 0; i < 16; i++) smp[i] = sample_t'(2 * i - 8);
        push_frame(112, 22, -8);
        burst(16);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            out_ready = (k % 2 == 0);
        end
        out_ready = 1'b1;
        wait_drain("drain_backpressure", 40);

        // Overflow: two frames stored, third dropped
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) smp[i] = 7'sd5;
        push_frame(80, 5, 5);
        burst(16);
        for (int i = 0; i < 16; i++) smp[i] = sample_t'(i - 8);
        push_frame(-8, 7, -8);
        burst(16);
        for (int i = 0; i < 16; i++) smp[i] = 7'sd9;
        burst(16);
        repeat (2) @(posedge clk); #1;
        chk("err_ovf_count", n_ovf, 1);
        chk("stall_beat0", {out_valid, out_idx, out_data}, {1'b1, 4'd0, 7'sd5});
        out_ready = 1'b1;
        wait_drain("drain_overflow", 80);
        chk("no_long_on_ovf", n_long, 0);

        // Short burst: discarded
        b0 = beats;
        for (int i = 0; i < 10; i++) smp[i] = sample_t'(i + 20);
        burst(10);
        repeat (30) @(posedge clk); #1;
        chk("err_short_count", n_short, 1);
        chk("short_no_replay", beats - b0, 0);

        // Long burst: first 16 replayed
        for (int i = 0; i < 18; i++) smp[i] = sample_t'(16 - i);
        push_frame(136, 16, 1);
        burst(18);
        wait_drain("drain_long", 60);
        chk("err_long_count", n_long, 1);
        chk("short_after_long", n_short, 1);

        // Reset mid-replay
        for (int i = 0; i < 16; i++) smp[i] = sample_t'(i);
        push_frame(120, 15, 0);
        burst(16);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("reset_mid_outputs", {out_valid, out_data, out_idx, out_last, out_sum,
                                  out_max, out_min, err_short, err_long, err_ovf}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        b0 = beats;
        repeat (40) @(posedge clk); #1;
        chk("reset_no_resume", beats - b0, 0);
        chk("reset_valid_low", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/cg_result_collector.md
# cg_result_collector

Downstream stage of the clock-gated image-op core. Consumes each 16-sample (4×4) signed result burst on the core's `out_valid`/`out_data` and checks the burst length. Buffers up to two complete frames in a ping-pong store. Replays each frame to a consumer over a valid/ready stream, with per-frame sum, max and min attached to the last beat.

## Interface
- `FRAME_LEN`, 16: samples per frame; fixed by the core's 4×4 output.
- `DW`, 7: sample width, signed two's complement.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cg_en` in 1: clock-gating enable for the bank registers; functionally transparent.
- `in_valid` in 1: sample strobe, driven by the core's `out_valid`.
- `in_data` in `DW`: signed sample, driven by the core's `out_data`.
- `out_valid` out 1: replay beat valid.
- `out_ready` in 1: consumer accepts the beat.
- `out_data` out `DW`: signed replay sample.
- `out_idx` out 4: sample index 0..15 within the frame.
- `out_last` out 1: high on beat 15.
- `out_sum` out 11: signed frame sum; valid with `out_last`, 0 otherwise.
- `out_max` out `DW`: signed frame max; valid with `out_last`, 0 otherwise.
- `out_min` out `DW`: signed frame min; valid with `out_last`, 0 otherwise.
- `err_short` out 1: one-cycle pulse; burst ended before 16 samples.
- `err_long` out 1: one-cycle pulse; burst ran past 16 samples.
- `err_ovf` out 1: one-cycle pulse; burst dropped because both banks were full.

## Operation
- Capture FSM states:
  - C_IDLE, C_FILL, C_DRAIN.
  - C_IDLE → C_FILL on `in_valid` with a free bank. That first sample is written at index 0. Banks are picked in ping-pong order.
  - C_IDLE → C_DRAIN on `in_valid` with no bank free. Pulse `err_ovf`.
  - In C_FILL, each `in_valid` sample is written at count `cnt` and accumulates sum, max and min.
  - When the 16th sample is written, the bank is marked full, sum/max/min are latched per bank, and the FSM goes → C_DRAIN.
  - If `in_valid` drops in C_FILL with `cnt` < 16: pulse `err_short`, discard the partial bank (it stays free), go → C_IDLE.
  - In C_DRAIN, if `in_valid` is still high on the cycle after the 16th sample: pulse `err_long` once per burst and ignore samples until `in_valid` drops, then → C_IDLE.
  - Overflow drain produces no `err_long`.
- Read FSM states:
  - R_IDLE, R_SEND.
  - R_IDLE → R_SEND when the oldest bank is full.
  - In R_SEND, beats are presented in index order. A beat advances only on `out_valid && out_ready`.
  - On the handshake of beat 15, the bank is freed. Go → R_IDLE, or straight into the next full bank with no bubble.
- Arithmetic:
  - Sum range is −1024..1008 and is held in 11-bit signed; no saturation is needed.
  - Max/min use signed compare.
  - Accumulators seed from sample 0 as sum = max = min = sample 0.
- Stream rules:
  - `out_data` is held stable while `out_valid && !out_ready`.
  - `out_valid` never drops without a handshake.
- `cg_en`:
  - When 1, bank write enables gate the bank registers.
  - When 0, the registers are clocked freely.
  - Output behaviour is identical in both cases.

## Timing
- Reset values (`rst`=1 on an edge):
  - FSMs go to C_IDLE / R_IDLE; both banks free; `cnt`=0.
  - Every output is 0: `out_valid`, `out_data`, `out_idx`, `out_last`, `out_sum`, `out_max`, `out_min`, all `err_*`.
  - Bank contents are don't-care.
- Reset mid-burst or mid-replay aborts both; nothing resumes afterward.
- Latency: 16th sample sampled at edge N → bank full at edge N → first `out_valid` high after edge N+1, with beat 0.
- With `out_ready` held high, 16 beats run back-to-back and back-to-back frames are seamless.
- Simultaneous free/start: a bank freed at edge E is usable only by a burst whose first sample arrives after E. A burst starting at E sees the bank as full.
- A 1-cycle `in_valid` gap splits a burst: the partial burst gets `err_short` and the next high cycle starts a new frame.
- Error pulses are registered and assert on the cycle after the detecting edge.

## Structure
- Package `cg_pkg`:
  - `FRAME_LEN`, `DW`, `SUM_W`=11.
  - Capture state enum and read state enum.
  - Typedef `sample_t` = signed [DW-1:0].
- Sub-module `cg_frame_bank`: one 16×`DW` register bank plus its latched sum/max/min. It takes write enable and address, read address, and `cg_en`. Instantiated twice.

## Test plan
- Reset: hold `rst` for 3 cycles mid-replay → all outputs 0 the cycle after; no further beats.
- Single frame with samples 0..15, `out_ready`=1 → beats 0..15 in order, first beat at N+1; `out_last` on 15; sum=120, max=15, min=0.
- Signed frame with −64 at index 3, 63 at index 9, rest −1 → sum=−15, max=63, min=−64.
- Backpressure: toggle `out_ready` 1-0-1-0 → each beat is held while not ready; no beat lost or duplicated.
- Three back-to-back bursts, `out_ready`=0 → frames 1 and 2 stored, `err_ovf` on burst 3. Then set `out_ready`=1 → frames 1 and 2 replayed in order.
- Length errors:
  - 10-sample burst → `err_short`, no replay.
  - 18-sample burst → `err_long`, first 16 samples replayed.
